fetch_decode_regs: RTL and testbench
====================================

Name: fetch_decode_regs

Overview:
- Architectural register stage directly upstream of the multicycle control unit: holds PC, instruction register (IR), data register (DR) and the Z/C flag register.
- Captures memory/ALU results under the control unit's enables (PCen, IRegen, DRegen, FlgWrite) and feeds back Op, Z and C.
- Also decodes IR into register-select and immediate fields, detects HALT (Op 5'b11111) and illegal opcodes, and counts fetched instructions.

Parameters:
- ADDR_W, 8, PC and memory address width.
- INSTR_W, 16, instruction and memory data width; field layout below is fixed for 16.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-low reset.
- PCen  in  1  load PC from pc_next.
- IRegen  in  1  load IR from mem_rdata.
- DRegen  in  1  load DR from mem_rdata.
- FlgWrite  in  1  load Z/C from alu_z/alu_c.
- pc_next  in  ADDR_W  next PC from datapath result mux.
- mem_rdata  in  INSTR_W  unified instruction/data memory read data.
- alu_z  in  1  ALU zero result.
- alu_c  in  1  ALU carry result.
- pc  out  ADDR_W  current PC.
- ir  out  INSTR_W  current instruction.
- dr  out  INSTR_W  memory data register.
- Op  out  5  ir[15:11].
- rd_sel  out  3  ir[10:8].
- rs_sel  out  3  ir[7:5].
- rt_sel  out  3  ir[4:2].
- imm  out  8  ir[7:0].
- Z  out  1  registered zero flag.
- C  out  1  registered carry flag.
- halted  out  1  core halted; sticky.
- illegal_op  out  1  an illegal opcode was fetched; sticky.
- instr_count  out  CNT_W  number of IR loads since reset.

Behaviour:
- Reset (RST==0 at posedge):
  - pc, ir, dr, Z, C, instr_count = 0.
  - halted = 0, illegal_op = 0, FSM = RUN.
  - Reset overrides all enables in the same cycle.
- Registers: one-cycle latency. Each updates at the posedge where its enable is high, subject to the FSM gating below.
  - PCen and IRegen together (fetch cycle): PC takes pc_next and IR takes mem_rdata, both sampled in the same cycle. The IR load is not affected by the PC update.
- Decoded fields (Op, rd_sel, rs_sel, rt_sel, imm) are combinational slices of registered ir. No extra latency.
- Legal opcodes:
  - 00xxx (all eight)
  - 01000–01100
  - 10000–10101 and 10111
  - 11000, 11001, 11010, 11111
  - Every other value is illegal.
- illegal_op: set at the posedge where IR loads an illegal opcode. Held until reset. Does not stop execution.
- FSM states:
  - RUN: all enables honoured. An IR load with opcode 11111 goes to HALT_PEND.
  - HALT_PEND: lasts exactly one cycle so the control unit can decode HALT. DRegen and FlgWrite are honoured; PCen and IRegen are ignored. Goes to HALTED.
  - HALTED: PCen, IRegen, DRegen and FlgWrite are all ignored; all registers frozen; halted = 1. Exits only via reset.
  - halted is 0 in RUN and HALT_PEND.
- instr_count increments by 1 on every honoured IR load, including the HALT word. It saturates at 2^CNT_W−1 and does not wrap.
- Flags: Z and C update only on FlgWrite, independent of IRegen and PCen.
- Reset mid-operation (any state, including HALTED): returns to RUN with all reset values on the next posedge.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants: OP_HALT = 5'b11111, OP_LDI, OP_LD, OP_ST, and the branch/shift/ALU opcode groups;
  - field bit positions (OP_MSB/OP_LSB, RD/RS/RT/IMM ranges);
  - FSM state encoding RUN, HALT_PEND, HALTED.
- One combinational sub-module, op_legal_check: input 5-bit opcode, output legal. The control unit may reuse it later.

Test Plan:
- Reset then fetch: RST low 2 cycles, then mem_rdata=16'h0A4C, pc_next=8'h01, PCen=IRegen=1 for one cycle -> pc=01, ir=0A4C, Op=5'b00001, rd_sel=2, rs_sel=2, rt_sel=3, imm=4C, instr_count=1.
- Flag write: alu_z=1, alu_c=0, FlgWrite=1 one cycle, then alu_z=0, FlgWrite=0 -> Z stays 1 and C=0; a later FlgWrite with alu_c=1 -> C=1.
- Halt: IRegen with mem_rdata=16'hF800 -> next cycle Op=11111 and halted=0 (HALT_PEND); cycle after, halted=1. Further PCen/IRegen/DRegen pulses with new data -> pc, ir, dr, instr_count unchanged.
- Illegal op: IR load of 16'h7000 (opcode 01110) -> illegal_op=1 next cycle. A subsequent legal load keeps illegal_op=1 and updates ir normally.
- Counter saturation with CNT_W=2: four IR loads -> instr_count=3 after the third and still 3 after the fourth.
- Reset while HALTED: assert RST low one cycle -> halted=0, pc=0, instr_count=0, illegal_op=0. The next fetch loads normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode register stage and the control unit:
// opcode constants, instruction field positions and the stage FSM states.
package cpu_pkg;

    // Instruction field bit positions (16-bit instruction word)
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 5;
    localparam int RT_MSB  = 4;
    localparam int RT_LSB  = 2;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Individual opcodes
    localparam logic [4:0] OP_HALT = 5'b11111;
    localparam logic [4:0] OP_LD   = 5'b01000;
    localparam logic [4:0] OP_ST   = 5'b01001;
    localparam logic [4:0] OP_LDI  = 5'b01010;

    // Opcode groups, identified by the top two opcode bits
    localparam logic [1:0] GRP_ALU    = 2'b00;  // 00000-00111
    localparam logic [1:0] GRP_MEM    = 2'b01;  // 01000-01100
    localparam logic [1:0] GRP_BRANCH = 2'b10;  // 10000-10101, 10111
    localparam logic [1:0] GRP_SHIFT  = 2'b11;  // 11000-11010 (11111 = HALT)

    // Stage FSM
    typedef enum logic [1:0] {
        RUN       = 2'b00,
        HALT_PEND = 2'b01,
        HALTED    = 2'b10
    } fsm_state_e;

endpackage

// File: rtl/op_legal_check.sv
// Combinational opcode legality check, shared with the control unit.
module op_legal_check
    import cpu_pkg::*;
(
    input  logic [4:0] op,
    output logic       legal
);

    // Decode legality from the opcode group and the low three bits
    always_comb begin
        legal = 1'b0;
        unique case (op[4:3])
            GRP_ALU:    legal = 1'b1;
            GRP_MEM:    legal = (op[2:0] <= 3'd4);
            GRP_BRANCH: legal = (op[2:0] <= 3'd5) || (op[2:0] == 3'd7);
            GRP_SHIFT:  legal = (op[2:0] <= 3'd2) || (op == OP_HALT);
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_regs.sv
// Architectural register stage feeding the multicycle control unit: PC, IR,
// DR and Z/C flags, IR field decode, HALT/illegal-opcode detection and a
// saturating fetched-instruction counter.
module fetch_decode_regs
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PCen,
    input  logic               IRegen,
    input  logic               DRegen,
    input  logic               FlgWrite,
    input  logic [ADDR_W-1:0]  pc_next,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               alu_z,
    input  logic               alu_c,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic [INSTR_W-1:0] dr,
    output logic [4:0]         Op,
    output logic [2:0]         rd_sel,
    output logic [2:0]         rs_sel,
    output logic [2:0]         rt_sel,
    output logic [7:0]         imm,
    output logic               Z,
    output logic               C,
    output logic               halted,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count
);

    fsm_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [INSTR_W-1:0] dr_q, dr_d;
    logic               z_q, z_d;
    logic               c_q, c_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pc_ld, ir_ld, dr_ld, flg_ld;
    logic [4:0]         fetch_op;
    logic               fetch_legal;

    assign fetch_op = mem_rdata[OP_MSB:OP_LSB];

    op_legal_check u_op_legal_check (
        .op    (fetch_op),
        .legal (fetch_legal)
    );

    // Gate the control unit's enables by FSM state
    always_comb begin
        pc_ld  = 1'b0;
        ir_ld  = 1'b0;
        dr_ld  = 1'b0;
        flg_ld = 1'b0;
        unique case (state_q)
            RUN: begin
                pc_ld  = PCen;
                ir_ld  = IRegen;
                dr_ld  = DRegen;
                flg_ld = FlgWrite;
            end
            HALT_PEND: begin
                dr_ld  = DRegen;
                flg_ld = FlgWrite;
            end
            default: ;
        endcase
    end

    // Next-state for the FSM and all architectural registers
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        dr_d      = dr_q;
        z_d       = z_q;
        c_d       = c_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            RUN:       if (ir_ld && fetch_op == OP_HALT) state_d = HALT_PEND;
            HALT_PEND: state_d = HALTED;
            HALTED:    state_d = HALTED;
            default:   state_d = RUN;
        endcase

        if (pc_ld) pc_d = pc_next;
        if (ir_ld) begin
            ir_d = mem_rdata;
            if (!fetch_legal) illegal_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        if (dr_ld) dr_d = mem_rdata;
        if (flg_ld) begin
            z_d = alu_z;
            c_d = alu_c;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= RUN;
            pc_q      <= '0;
            ir_q      <= '0;
            dr_q      <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            dr_q      <= dr_d;
            z_q       <= z_d;
            c_q       <= c_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign dr          = dr_q;
    assign Op          = ir_q[OP_MSB:OP_LSB];
    assign rd_sel      = ir_q[RD_MSB:RD_LSB];
    assign rs_sel      = ir_q[RS_MSB:RS_LSB];
    assign rt_sel      = ir_q[RT_MSB:RT_LSB];
    assign imm         = ir_q[IMM_MSB:IMM_LSB];
    assign Z           = z_q;
    assign C           = c_q;
    assign halted      = (state_q == HALTED);
    assign illegal_op  = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_decode_regs.sv
// Scoreboard bench for fetch_decode_regs: directed scenarios followed by
// random traffic, expected state from a behavioural model, checked by a monitor.
module tb_fetch_decode_regs;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        PCen = 1'b0, IRegen = 1'b0, DRegen = 1'b0, FlgWrite = 1'b0;
    logic [7:0]  pc_next = '0;
    logic [15:0] mem_rdata = '0;
    logic        alu_z = 1'b0, alu_c = 1'b0;

    logic [7:0]  pc;
    logic [15:0] ir, dr;
    logic [4:0]  Op;
    logic [2:0]  rd_sel, rs_sel, rt_sel;
    logic [7:0]  imm;
    logic        Z, C, halted, illegal_op;
    logic [15:0] instr_count;

    logic [7:0]  s_pc;
    logic [15:0] s_ir, s_dr;
    logic [4:0]  s_Op;
    logic [2:0]  s_rd, s_rs, s_rt;
    logic [7:0]  s_imm;
    logic        s_Z, s_C, s_halted, s_ill;
    logic [1:0]  s_cnt;

    always #5 CLK = ~CLK;

    fetch_decode_regs #(.ADDR_W(8), .INSTR_W(16), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .PCen(PCen), .IRegen(IRegen), .DRegen(DRegen),
        .FlgWrite(FlgWrite), .pc_next(pc_next), .mem_rdata(mem_rdata),
        .alu_z(alu_z), .alu_c(alu_c), .pc(pc), .ir(ir), .dr(dr), .Op(Op),
        .rd_sel(rd_sel), .rs_sel(rs_sel), .rt_sel(rt_sel), .imm(imm), .Z(Z),
        .C(C), .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    fetch_decode_regs #(.ADDR_W(8), .INSTR_W(16), .CNT_W(2)) dut_s (
        .CLK(CLK), .RST(RST), .PCen(PCen), .IRegen(IRegen), .DRegen(DRegen),
        .FlgWrite(FlgWrite), .pc_next(pc_next), .mem_rdata(mem_rdata),
        .alu_z(alu_z), .alu_c(alu_c), .pc(s_pc), .ir(s_ir), .dr(s_dr), .Op(s_Op),
        .rd_sel(s_rd), .rs_sel(s_rs), .rt_sel(s_rt), .imm(s_imm), .Z(s_Z),
        .C(s_C), .halted(s_halted), .illegal_op(s_ill), .instr_count(s_cnt)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [15:0] dr;
        logic        z;
        logic        c;
        logic        halted;
        logic        ill;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Behavioural model state
    logic [7:0]  m_pc;
    logic [15:0] m_ir, m_dr;
    logic        m_z, m_c, m_ill, m_halted, m_pend;
    int          m_cnt;

    function automatic bit op_is_legal(input logic [4:0] op);
        return op inside {[5'd0:5'd7], [5'd8:5'd12], [5'd16:5'd21], 5'd23,
                          5'd24, 5'd25, 5'd26, 5'd31};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected result
    task automatic cycle(input bit rst_n, input bit pcen, input bit iren,
                         input bit dren, input bit flg, input logic [7:0] pcn,
                         input logic [15:0] mem, input bit z, input bit c);
        bit   run;
        exp_t e;
        @(negedge CLK);
        RST = rst_n; PCen = pcen; IRegen = iren; DRegen = dren; FlgWrite = flg;
        pc_next = pcn; mem_rdata = mem; alu_z = z; alu_c = c;
        if (!rst_n) begin
            m_pc = '0; m_ir = '0; m_dr = '0; m_z = 0; m_c = 0;
            m_ill = 0; m_halted = 0; m_pend = 0; m_cnt = 0;
        end else begin
            run = !m_halted && !m_pend;
            if (run && iren) begin
                m_ir = mem;
                m_cnt++;
                if (!op_is_legal(mem[15:11])) m_ill = 1;
            end
            if (run && pcen) m_pc = pcn;
            if (!m_halted && dren) m_dr = mem;
            if (!m_halted && flg) begin m_z = z; m_c = c; end
            m_halted = m_halted || m_pend;
            m_pend   = run && iren && (mem[15:11] == 5'b11111);
        end
        e.pc = m_pc; e.ir = m_ir; e.dr = m_dr; e.z = m_z; e.c = m_c;
        e.halted = m_halted; e.ill = m_ill;
        e.cnt   = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e.cnt_s = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cycle(1, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0);
    endtask

    // Monitor: after each edge, pop the pending expectation and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", 128'(pc), 128'(e.pc));
                check("ir", 128'(ir), 128'(e.ir));
                check("dr", 128'(dr), 128'(e.dr));
                check("fields", 128'({Op, rd_sel, rs_sel, rt_sel, imm}),
                      128'({e.ir[15:11], e.ir[10:8], e.ir[7:5], e.ir[4:2], e.ir[7:0]}));
                check("Z", 128'(Z), 128'(e.z));
                check("C", 128'(C), 128'(e.c));
                check("halted", 128'(halted), 128'(e.halted));
                check("illegal_op", 128'(illegal_op), 128'(e.ill));
                check("instr_count", 128'(instr_count), 128'(e.cnt));
                check("small_count", 128'(s_cnt), 128'(e.cnt_s));
                check("small_regs",
                      128'({s_pc, s_ir, s_dr, s_Op, s_rd, s_rs, s_rt, s_imm, s_Z, s_C, s_halted, s_ill}),
                      128'({e.pc, e.ir, e.dr, e.ir[15:11], e.ir[10:8], e.ir[7:5], e.ir[4:2],
                            e.ir[7:0], e.z, e.c, e.halted, e.ill}));
            end
        end
    end

    initial begin
        logic [15:0] w;
        // Reset then fetch
        cycle(0, 1, 1, 1, 1, 8'hAA, 16'h1234, 1, 1);
        cycle(0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0);
        cycle(1, 1, 1, 0, 0, 8'h01, 16'h0A4C, 0, 0);
        idle();
        // Flag write, hold, then carry
        cycle(1, 0, 0, 0, 1, 8'h00, 16'h0000, 1, 0);
        cycle(1, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 1);
        cycle(1, 0, 0, 0, 1, 8'h00, 16'h0000, 1, 1);
        // Data register load
        cycle(1, 0, 0, 1, 0, 8'h00, 16'hBEEF, 0, 0);
        // Illegal opcode, then a legal load
        cycle(1, 0, 1, 0, 0, 8'h00, 16'h7000, 0, 0);
        cycle(1, 1, 1, 0, 0, 8'h05, 16'h4123, 0, 0);
        // Further loads saturate the 2-bit counter
        cycle(1, 0, 1, 0, 0, 8'h00, 16'h0811, 0, 0);
        cycle(1, 0, 1, 0, 0, 8'h00, 16'hC0FF, 0, 0);
        // Halt with fetch; next cycle DR/flags honoured but not PC/IR
        cycle(1, 1, 1, 0, 0, 8'h10, 16'hF800, 0, 0);
        cycle(1, 1, 1, 1, 1, 8'h20, 16'h1357, 0, 1);
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 1, 1, 1, 8'(8'h30 + i), 16'h2468, 1, 0);
        // Reset while halted, then a normal fetch
        cycle(0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0);
        cycle(1, 1, 1, 0, 0, 8'h02, 16'h0A4C, 0, 0);
        // Random traffic with occasional HALT words and resets
        for (int i = 0; i < 600; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 9) == 0) w[15:11] = 5'b11111;
            cycle($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 8'($urandom), w,
                  1'($urandom), 1'($urandom));
        end
        idle();
        @(negedge CLK);
        @(negedge CLK);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
